// File: rtl/lf_spi_pkg.sv
// Shared constants and types for the LF SPI command receiver.
package lf_spi_pkg;

  localparam int         DEF_FRAME_BITS = 16;
  localparam logic [7:0] DEF_DIVISOR    = 8'd95;
  localparam logic [7:0] DEF_THRESHOLD  = 8'd127;

  localparam logic [3:0] CMD_SET_CONF       = 4'b0001;
  localparam logic [3:0] CMD_SET_DIVISOR    = 4'b0010;
  localparam logic [3:0] CMD_SET_USER_BYTE1 = 4'b0011;

  localparam logic [7:0] CONF_EDGE_DETECT = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DECODE
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with a delayed copy for rise/fall detection.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic pck0,
  input  logic nrst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic dly;

  always_ff @(posedge pck0) begin
    if (!nrst) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      dly  <= RST_VAL;
    end else begin
      meta <= d;
      sync <= meta;
      dly  <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~dly;
  assign fall  = ~sync & dly;

endmodule

// File: rtl/lf_spi_cmd_rx.sv
// SPI command receiver: assembles 16-bit frames from the ARM, decodes them
// into the LF configuration registers and shifts a register snapshot on miso.
//
// state  | meaning
// IDLE   | waiting for ncs to fall; miso held at 0
// SHIFT  | frame in progress; rx shifts on spck rise, tx on spck fall
// DECODE | one cycle: length/opcode check, register update, strobe
module lf_spi_cmd_rx
  import lf_spi_pkg::*;
#(
  parameter int         FRAME_BITS        = DEF_FRAME_BITS,
  parameter logic [7:0] DEFAULT_DIVISOR   = DEF_DIVISOR,
  parameter logic [7:0] DEFAULT_THRESHOLD = DEF_THRESHOLD
) (
  input  logic       pck0,
  input  logic       nrst,
  input  logic       spck,
  input  logic       mosi,
  input  logic       ncs,
  output logic       miso,
  output logic [7:0] conf_word,
  output logic [7:0] divisor,
  output logic [7:0] user_byte1,
  output logic       cmd_valid,
  output logic       cmd_err
);

  localparam int               CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic spck_s, spck_rise, spck_fall;
  logic ncs_s, ncs_rise, ncs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [15:0]      rx_sr;
  logic [15:0]      tx_sr;
  logic [1:0]       flush_cnt;
  logic             ncs_armed;
  logic             frame_start;

  sync_edge #(.RST_VAL(1'b0)) u_sync_spck (
    .pck0(pck0), .nrst(nrst), .d(spck),
    .level(spck_s), .rise(spck_rise), .fall(spck_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
    .pck0(pck0), .nrst(nrst), .d(ncs),
    .level(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .pck0(pck0), .nrst(nrst), .d(mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // A frame may only start once ncs has been seen high after reset, so a
  // chip select already low at reset release cannot open a partial frame.
  assign frame_start = ncs_fall & ncs_armed;
  assign miso        = tx_sr[15];

  always_ff @(posedge pck0) begin
    if (!nrst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      flush_cnt  <= '0;
      ncs_armed  <= 1'b0;
      conf_word  <= 8'h00;
      divisor    <= DEFAULT_DIVISOR;
      user_byte1 <= DEFAULT_THRESHOLD;
      cmd_valid  <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;

      if (flush_cnt != 2'd2) flush_cnt <= flush_cnt + 2'd1;
      else if (ncs_s) ncs_armed <= 1'b1;

      case (state)
        IDLE: begin
          tx_sr <= '0;
          if (frame_start) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            tx_sr   <= {conf_word, user_byte1};
          end
        end

        SHIFT: begin
          if (ncs_rise) begin
            state <= DECODE;
          end else if (spck_rise && !ncs_s) begin
            rx_sr <= {rx_sr[14:0], mosi_s};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
          end else if (spck_fall) begin
            tx_sr <= {tx_sr[14:0], 1'b0};
          end
        end

        DECODE: begin
          if (bit_cnt == CNT_FULL) begin
            case (rx_sr[15:12])
              CMD_SET_CONF: begin
                conf_word <= rx_sr[7:0];
                if (rx_sr[7:0] == CONF_EDGE_DETECT) user_byte1 <= DEFAULT_THRESHOLD;
                cmd_valid <= 1'b1;
              end
              CMD_SET_DIVISOR: begin
                divisor   <= rx_sr[7:0];
                cmd_valid <= 1'b1;
              end
              CMD_SET_USER_BYTE1: begin
                user_byte1 <= rx_sr[7:0];
                cmd_valid  <= 1'b1;
              end
              default: cmd_err <= 1'b1;
            endcase
          end else begin
            cmd_err <= 1'b1;
          end

          // Back-to-back frame: snapshot is taken before this cycle's update.
          state <= IDLE;
          tx_sr <= '0;
          if (frame_start) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            tx_sr   <= {conf_word, user_byte1};
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lf_spi_cmd_rx.sv
// Directed bench for lf_spi_cmd_rx: frames driven at pck0/16 spck rate.
module tb_lf_spi_cmd_rx;

  logic       pck0 = 1'b0;
  logic       nrst = 1'b0;
  logic       spck = 1'b0;
  logic       mosi = 1'b0;
  logic       ncs  = 1'b1;
  logic       miso;
  logic [7:0] conf_word;
  logic [7:0] divisor;
  logic [7:0] user_byte1;
  logic       cmd_valid;
  logic       cmd_err;

  int checks  = 0;
  int errors  = 0;
  int n_valid = 0;
  int n_err   = 0;
  int v0, e0;
  logic [31:0] rd, rd2;

  always #5 pck0 = ~pck0;

  lf_spi_cmd_rx dut (
    .pck0(pck0), .nrst(nrst), .spck(spck), .mosi(mosi), .ncs(ncs),
    .miso(miso), .conf_word(conf_word), .divisor(divisor),
    .user_byte1(user_byte1), .cmd_valid(cmd_valid), .cmd_err(cmd_err)
  );

  always @(negedge pck0) begin
    if (cmd_valid) n_valid++;
    if (cmd_err) n_err++;
    if (cmd_valid && cmd_err) begin
      errors++;
      $display("FAIL strobe_overlap valid=%b err=%b want not both", cmd_valid, cmd_err);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic shift_bits(input logic [31:0] data, input int nbits, output logic [31:0] r);
    r = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = data[i];
      repeat (8) @(negedge pck0);
      r = {r[30:0], miso};
      spck = 1'b1;
      repeat (8) @(negedge pck0);
      spck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] data, input int nbits, output logic [31:0] r);
    ncs = 1'b0;
    repeat (8) @(negedge pck0);
    shift_bits(data, nbits, r);
    repeat (8) @(negedge pck0);
    ncs = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (5) @(negedge pck0);
    nrst = 1'b1;
    repeat (100) @(negedge pck0);
    checks++; if (conf_word !== 8'h00) begin errors++; $display("FAIL rst_conf got %h want %h", conf_word, 8'h00); end
    checks++; if (divisor !== 8'd95) begin errors++; $display("FAIL rst_div got %h want %h", divisor, 8'd95); end
    checks++; if (user_byte1 !== 8'd127) begin errors++; $display("FAIL rst_ub1 got %h want %h", user_byte1, 8'd127); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rst_miso got %b want 0", miso); end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL rst_valid got %0d want 0", n_valid); end
    checks++; if (n_err !== 0) begin errors++; $display("FAIL rst_err got %0d want 0", n_err); end
  endtask

  task automatic test_set_divisor();
    v0 = n_valid; e0 = n_err;
    send_frame(32'h2050, 16, rd);
    repeat (3) @(posedge pck0);
    #1;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL div_early_valid got %b want 0", cmd_valid); end
    checks++; if (divisor !== 8'd95) begin errors++; $display("FAIL div_early got %h want %h", divisor, 8'd95); end
    @(posedge pck0);
    #1;
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL div_valid_4th got %b want 1", cmd_valid); end
    checks++; if (divisor !== 8'h50) begin errors++; $display("FAIL div_4th got %h want %h", divisor, 8'h50); end
    @(negedge pck0);
    repeat (8) @(negedge pck0);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL div_valid_cnt got %0d want 1", n_valid - v0); end
    checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL div_err_cnt got %0d want 0", n_err - e0); end
    checks++; if (conf_word !== 8'h00) begin errors++; $display("FAIL div_conf got %h want %h", conf_word, 8'h00); end
    checks++; if (user_byte1 !== 8'h7F) begin errors++; $display("FAIL div_ub1 got %h want %h", user_byte1, 8'h7F); end
    checks++; if (rd[15:0] !== 16'h007F) begin errors++; $display("FAIL div_readback got %h want %h", rd[15:0], 16'h007F); end
  endtask

  task automatic test_threshold_reload();
    v0 = n_valid;
    send_frame(32'h30C8, 16, rd);
    repeat (8) @(negedge pck0);
    checks++; if (user_byte1 !== 8'hC8) begin errors++; $display("FAIL ub1_set got %h want %h", user_byte1, 8'hC8); end
    send_frame(32'h1001, 16, rd);
    repeat (8) @(negedge pck0);
    checks++; if (conf_word !== 8'h01) begin errors++; $display("FAIL edge_conf got %h want %h", conf_word, 8'h01); end
    checks++; if (user_byte1 !== 8'h7F) begin errors++; $display("FAIL edge_reload got %h want %h", user_byte1, 8'h7F); end
    checks++; if (n_valid - v0 !== 2) begin errors++; $display("FAIL reload_valid_cnt got %0d want 2", n_valid - v0); end
  endtask

  task automatic test_length_errors();
    v0 = n_valid; e0 = n_err;
    send_frame(32'h1033, 15, rd);
    repeat (8) @(negedge pck0);
    send_frame(32'h12077, 17, rd);
    repeat (8) @(negedge pck0);
    send_frame(32'h4055, 16, rd);
    repeat (8) @(negedge pck0);
    checks++; if (n_err - e0 !== 3) begin errors++; $display("FAIL lenerr_cnt got %0d want 3", n_err - e0); end
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL lenerr_valid got %0d want 0", n_valid - v0); end
    checks++; if (conf_word !== 8'h01) begin errors++; $display("FAIL lenerr_conf got %h want %h", conf_word, 8'h01); end
    checks++; if (divisor !== 8'h50) begin errors++; $display("FAIL lenerr_div got %h want %h", divisor, 8'h50); end
    checks++; if (user_byte1 !== 8'h7F) begin errors++; $display("FAIL lenerr_ub1 got %h want %h", user_byte1, 8'h7F); end
  endtask

  task automatic test_readback();
    send_frame(32'h1022, 16, rd);
    repeat (8) @(negedge pck0);
    send_frame(32'h307F, 16, rd);
    repeat (8) @(negedge pck0);
    send_frame(32'h10A0, 16, rd);
    repeat (8) @(negedge pck0);
    checks++; if (rd[15:0] !== 16'h227F) begin errors++; $display("FAIL readback got %h want %h", rd[15:0], 16'h227F); end
    checks++; if (conf_word !== 8'hA0) begin errors++; $display("FAIL readback_conf got %h want %h", conf_word, 8'hA0); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL readback_idle_miso got %b want 0", miso); end
  endtask

  task automatic test_back_to_back();
    v0 = n_valid;
    send_frame(32'h1055, 16, rd);
    @(negedge pck0);
    ncs = 1'b0;
    repeat (8) @(negedge pck0);
    shift_bits(32'h3000, 16, rd2);
    repeat (8) @(negedge pck0);
    ncs = 1'b1;
    repeat (8) @(negedge pck0);
    checks++; if (rd2[15:0] !== 16'hA07F) begin errors++; $display("FAIL b2b_readback got %h want %h", rd2[15:0], 16'hA07F); end
    checks++; if (conf_word !== 8'h55) begin errors++; $display("FAIL b2b_conf got %h want %h", conf_word, 8'h55); end
    checks++; if (user_byte1 !== 8'h00) begin errors++; $display("FAIL b2b_ub1 got %h want %h", user_byte1, 8'h00); end
    checks++; if (n_valid - v0 !== 2) begin errors++; $display("FAIL b2b_valid_cnt got %0d want 2", n_valid - v0); end
  endtask

  task automatic test_reset_mid_frame();
    ncs = 1'b0;
    repeat (8) @(negedge pck0);
    shift_bits(32'h20, 8, rd);
    nrst = 1'b0;
    repeat (2) @(negedge pck0);
    checks++; if (conf_word !== 8'h00) begin errors++; $display("FAIL midrst_conf got %h want %h", conf_word, 8'h00); end
    checks++; if (divisor !== 8'd95) begin errors++; $display("FAIL midrst_div got %h want %h", divisor, 8'd95); end
    checks++; if (user_byte1 !== 8'd127) begin errors++; $display("FAIL midrst_ub1 got %h want %h", user_byte1, 8'd127); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL midrst_miso got %b want 0", miso); end
    nrst = 1'b1;
    v0 = n_valid; e0 = n_err;
    shift_bits(32'h11, 8, rd);
    repeat (8) @(negedge pck0);
    ncs = 1'b1;
    repeat (20) @(negedge pck0);
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL midrst_valid got %0d want 0", n_valid - v0); end
    checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL midrst_err got %0d want 0", n_err - e0); end
    checks++; if (divisor !== 8'd95) begin errors++; $display("FAIL midrst_tail_div got %h want %h", divisor, 8'd95); end
    send_frame(32'h2011, 16, rd);
    repeat (8) @(negedge pck0);
    checks++; if (divisor !== 8'h11) begin errors++; $display("FAIL midrst_next_div got %h want %h", divisor, 8'h11); end
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL midrst_next_valid got %0d want 1", n_valid - v0); end
  endtask

  initial begin
    test_reset();
    test_set_divisor();
    test_threshold_reload();
    test_length_errors();
    test_readback();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
